seven_seg_scan_capture: RTL and testbench

Passive reader for the team's multiplexed 4-digit seven-segment interface (active-low anodes, active-low cathodes). It samples the anode/cathode lines a display controller drives and decodes each digit's cathode pattern back to BCD. It assembles a full 4-digit frame and reports it as packed BCD and as a binary value. It is used on-board for self-check and ILA probing, and in benches as the scoreboard front end for display controllers.

---
 rtl/seven_seg_pkg.sv | 60 ++++++
 rtl/seven_seg_pattern_decoder.sv | 33 +++
 rtl/seven_seg_scan_capture.sv | 157 +++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: cathode patterns, anode codes, capture FSM
// states and helpers used by display controllers, the capture block and benches.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [3:0] AN_D3    = 4'b0111;
  localparam logic [3:0] AN_D2    = 4'b1011;
  localparam logic [3:0] AN_D1    = 4'b1101;
  localparam logic [3:0] AN_D0    = 4'b1110;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  function automatic logic anode_valid(input logic [3:0] an);
    case (an)
      AN_D3, AN_D2, AN_D1, AN_D0: anode_valid = 1'b1;
      default:                    anode_valid = 1'b0;
    endcase
  endfunction

  function automatic digit_idx_t anode_digit(input logic [3:0] an);
    case (an)
      AN_D3:   anode_digit = 2'd3;
      AN_D2:   anode_digit = 2'd2;
      AN_D1:   anode_digit = 2'd1;
      default: anode_digit = 2'd0;
    endcase
  endfunction

  // 1000 = 512+256+128+64+32+8, 100 = 64+32+4, 10 = 8+2: shift-add only.
  function automatic logic [15:0] bcd_to_bin(input logic [15:0] bcd);
    logic [15:0] d3, d2, d1, d0;
    d3 = {12'd0, bcd[15:12]};
    d2 = {12'd0, bcd[11:8]};
    d1 = {12'd0, bcd[7:4]};
    d0 = {12'd0, bcd[3:0]};
    bcd_to_bin = (d3 << 4'd9) + (d3 << 4'd8) + (d3 << 4'd7) + (d3 << 4'd6)
               + (d3 << 4'd5) + (d3 << 4'd3)
               + (d2 << 4'd6) + (d2 << 4'd5) + (d2 << 4'd2)
               + (d1 << 4'd3) + (d1 << 4'd1)
               + d0;
  endfunction

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// Combinational cathode-pattern to BCD decoder; valid is low for any pattern
// that is not one of the ten digit glyphs.
module seven_seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] bcd
);

  // Glyph lookup
  always_comb begin
    valid = 1'b1;
    bcd   = 4'd0;
    case (pattern)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: begin
        valid = 1'b0;
        bcd   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Passive reader of a multiplexed 4-digit seven-segment bus: samples each digit
// once per dwell after the anode settles and assembles complete frames.
module seven_seg_scan_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  Anode_Activate,
  input  logic [6:0]  LED_out,
  output logic        frame_valid,
  output logic [15:0] frame_bcd,
  output logic [15:0] frame_value,
  output logic        digit_error,
  output logic        timeout
);

  localparam int STABLE_W = $clog2(STABLE_CYCLES);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_PRE      = TO_W'(TIMEOUT_CYCLES - 2);

  logic [3:0]          an_r, cur_an_r, mask_r, new_mask_s;
  logic [6:0]          led_r;
  state_t              state_r;
  logic [STABLE_W-1:0] stable_cnt_r;
  logic [15:0]         store_r, new_store_s, frame_bcd_r, frame_value_r;
  logic                frame_pending_r, frame_valid_r, digit_error_r, timeout_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic                seg_valid_s, sample_s;
  logic [3:0]          seg_bcd_s;
  digit_idx_t          digit_s;

  seven_seg_pattern_decoder u_decoder (
    .pattern (led_r),
    .valid   (seg_valid_s),
    .bcd     (seg_bcd_s)
  );

  // Input capture register
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      an_r  <= AN_BLANK;
      led_r <= 7'h7F;
    end else begin
      an_r  <= Anode_Activate;
      led_r <= LED_out;
    end
  end

  // Sample strobe and next mask/store for the digit currently lit
  always_comb begin
    digit_s     = anode_digit(cur_an_r);
    new_mask_s  = mask_r | (4'b0001 << digit_s);
    new_store_s = store_r;
    if ((state_r == SETTLE) && (an_r == cur_an_r) && (stable_cnt_r == STABLE_LAST)) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
    case (digit_s)
      2'd3:    new_store_s[15:12] = seg_bcd_s;
      2'd2:    new_store_s[11:8]  = seg_bcd_s;
      2'd1:    new_store_s[7:4]   = seg_bcd_s;
      default: new_store_s[3:0]   = seg_bcd_s;
    endcase
  end

  // Dwell-tracking FSM and digit capture
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_r         <= IDLE;
      stable_cnt_r    <= {STABLE_W{1'b0}};
      cur_an_r        <= AN_BLANK;
      mask_r          <= 4'd0;
      store_r         <= 16'd0;
      frame_bcd_r     <= 16'd0;
      frame_pending_r <= 1'b0;
      digit_error_r   <= 1'b0;
    end else begin
      frame_pending_r <= 1'b0;
      digit_error_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (anode_valid(an_r)) begin
            state_r      <= SETTLE;
            stable_cnt_r <= {STABLE_W{1'b0}};
            cur_an_r     <= an_r;
          end
        end
        SETTLE, HOLD: begin
          if (an_r != cur_an_r) begin
            state_r      <= anode_valid(an_r) ? SETTLE : IDLE;
            stable_cnt_r <= {STABLE_W{1'b0}};
            cur_an_r     <= an_r;
          end else if (state_r == SETTLE) begin
            if (stable_cnt_r == STABLE_LAST) begin
              state_r <= HOLD;
            end else begin
              stable_cnt_r <= stable_cnt_r + 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase

      // An undecodable glyph discards the partial frame but keeps the store.
      if (sample_s) begin
        if (seg_valid_s) begin
          store_r <= new_store_s;
          if (new_mask_s == 4'b1111) begin
            mask_r          <= 4'd0;
            frame_bcd_r     <= new_store_s;
            frame_pending_r <= 1'b1;
          end else begin
            mask_r <= new_mask_s;
          end
        end else begin
          digit_error_r <= 1'b1;
          mask_r        <= 4'd0;
        end
      end
    end
  end

  // Frame presentation and timeout watchdog; a frame always beats a new timeout
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      frame_valid_r <= 1'b0;
      frame_value_r <= 16'd0;
      to_cnt_r      <= {TO_W{1'b0}};
      timeout_r     <= 1'b0;
    end else begin
      frame_valid_r <= frame_pending_r;
      if (frame_pending_r) begin
        frame_value_r <= bcd_to_bin(frame_bcd_r);
        to_cnt_r      <= {TO_W{1'b0}};
        timeout_r     <= 1'b0;
      end else if (to_cnt_r != TO_LAST) begin
        to_cnt_r <= to_cnt_r + 1'b1;
        if (to_cnt_r == TO_PRE) begin
          timeout_r <= 1'b1;
        end
      end
    end
  end

  assign frame_valid = frame_valid_r;
  assign frame_bcd   = frame_bcd_r;
  assign frame_value = frame_value_r;
  assign digit_error = digit_error_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture: drives scans of known digits and
// compares the captured frame, pulses and timeout against hand-computed values.
module tb_seven_seg_scan_capture;

  logic        clock_100Mhz = 1'b0;
  logic        reset;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;
  logic        frame_valid;
  logic [15:0] frame_bcd;
  logic [15:0] frame_value;
  logic        digit_error;
  logic        timeout;

  int n_compared   = 0;
  int n_mismatched = 0;
  int fv_cnt, de_cnt, fv_at;
  logic to_at_fv;

  seven_seg_scan_capture #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clock_100Mhz   (clock_100Mhz),
    .reset          (reset),
    .Anode_Activate (Anode_Activate),
    .LED_out        (LED_out),
    .frame_valid    (frame_valid),
    .frame_bcd      (frame_bcd),
    .frame_value    (frame_value),
    .digit_error    (digit_error),
    .timeout        (timeout)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      default: seg_of = 7'b0000100;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int d);
    case (d)
      3:       an_of = 4'b0111;
      2:       an_of = 4'b1011;
      1:       an_of = 4'b1101;
      default: an_of = 4'b1110;
    endcase
  endfunction

  task automatic clear_counts();
    fv_cnt   = 0;
    de_cnt   = 0;
    fv_at    = 0;
    to_at_fv = 1'bx;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    Anode_Activate = 4'b1111;
    LED_out        = 7'b1111111;
    @(posedge clock_100Mhz); #1;
    reset = 1'b0;
  endtask

  // Hold one anode/cathode pair; fv_at is the 1-based cycle index of frame_valid.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    Anode_Activate = an;
    LED_out        = seg;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clock_100Mhz); #1;
      if (frame_valid) begin
        fv_cnt++;
        fv_at    = i;
        to_at_fv = timeout;
      end
      if (digit_error) de_cnt++;
    end
  endtask

  task automatic scan(input logic [15:0] bcd, input int short_digit, input int bad_digit);
    clear_counts();
    for (int d = 3; d >= 0; d--) begin
      logic [6:0] seg;
      int cyc;
      seg = seg_of(bcd[d*4 +: 4]);
      if (d == bad_digit) seg = 7'b1111111;
      cyc = (d == short_digit) ? 8 : 32;
      dwell(an_of(d), seg, cyc);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"},   {31'd0, frame_valid}, 32'd0);
    check({tag, "_bcd"},     {16'd0, frame_bcd},   32'd0);
    check({tag, "_value"},   {16'd0, frame_value}, 32'd0);
    check({tag, "_err"},     {31'd0, digit_error}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout},     32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    Anode_Activate = 4'b1111;
    LED_out        = 7'b1111111;
    repeat (2) @(posedge clock_100Mhz);
    #1;

    // Timeout with blank anodes, then cleared by a frame
    do_reset();
    check_cleared("rst");
    repeat (998) @(posedge clock_100Mhz);
    #1;
    check("to_998", {31'd0, timeout}, 32'd0);
    @(posedge clock_100Mhz); #1;
    check("to_999", {31'd0, timeout}, 32'd1);
    repeat (20) @(posedge clock_100Mhz);
    #1;
    check("to_held", {31'd0, timeout}, 32'd1);
    scan(16'h1000, -1, -1);
    check("to_fv_cnt", fv_cnt, 32'd1);
    check("to_at_fv", {31'd0, to_at_fv}, 32'd0);
    check("to_value", {16'd0, frame_value}, 32'h03E8);
    check("to_bcd", {16'd0, frame_bcd}, 32'h1000);

    // Clean scan of 1234 and its latency
    do_reset();
    scan(16'h1234, -1, -1);
    check("s1234_cnt", fv_cnt, 32'd1);
    check("s1234_lat", fv_at, 32'd19);
    check("s1234_bcd", {16'd0, frame_bcd}, 32'h1234);
    check("s1234_val", {16'd0, frame_value}, 32'h04D2);
    check("s1234_err", de_cnt, 32'd0);
    check("s1234_to", {31'd0, timeout}, 32'd0);

    // 9999 then 0000
    scan(16'h9999, -1, -1);
    check("s9999_cnt", fv_cnt, 32'd1);
    check("s9999_val", {16'd0, frame_value}, 32'h270F);
    check("s9999_bcd", {16'd0, frame_bcd}, 32'h9999);
    scan(16'h0000, -1, -1);
    check("s0000_cnt", fv_cnt, 32'd1);
    check("s0000_val", {16'd0, frame_value}, 32'h0000);
    check("s0000_err", de_cnt, 32'd0);

    // Short dwell on digit 2
    do_reset();
    scan(16'h4321, 2, -1);
    check("short_cnt", fv_cnt, 32'd0);
    check("short_err", de_cnt, 32'd0);
    scan(16'h4321, -1, -1);
    check("short_next_cnt", fv_cnt, 32'd1);
    check("short_next_val", {16'd0, frame_value}, 32'h10E1);

    // Undecodable glyph on digit 1
    do_reset();
    scan(16'h5678, -1, 1);
    check("bad_err", de_cnt, 32'd1);
    check("bad_cnt", fv_cnt, 32'd0);
    scan(16'h5678, -1, -1);
    check("bad_next_cnt", fv_cnt, 32'd1);
    check("bad_next_val", {16'd0, frame_value}, 32'h162E);
    check("bad_next_err", de_cnt, 32'd0);

    // Reset after three captured digits
    do_reset();
    scan(16'h5678, -1, -1);
    check("pre_val", {16'd0, frame_value}, 32'h162E);
    clear_counts();
    dwell(4'b0111, seg_of(4'd2), 32);
    dwell(4'b1011, seg_of(4'd4), 32);
    dwell(4'b1101, seg_of(4'd6), 32);
    check("mid_cnt", fv_cnt, 32'd0);
    do_reset();
    check_cleared("mid_rst");
    clear_counts();
    dwell(4'b1110, seg_of(4'd8), 32);
    check("lone_cnt", fv_cnt, 32'd0);
    scan(16'h2468, -1, -1);
    check("after_cnt", fv_cnt, 32'd1);
    check("after_val", {16'd0, frame_value}, 32'h09A4);
    check("after_bcd", {16'd0, frame_bcd}, 32'h2468);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
